tdm_demux_1_n: RTL and testbench

- Time-division demultiplexer: the receive-side counterpart of the 2:1/N:1 multiplexers in this codebase.
- Accepts one serial sample stream, with a start-of-frame marker, carrying N_CH interleaved channels.
- Steers each sample into its channel slot and presents a complete parallel frame with a one-cycle valid strobe.
- Sits between a TDM link and per-channel consumers.

---
 rtl/tdm_demux_1_n.sv | 85 ++++++++
 tb/tb_tdm_demux_1_n.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/tdm_demux_1_n.sv
// TDM demultiplexer: steers a serial sof-marked sample stream into N_CH parallel channel slots.
// Latency: f/f_valid register on the edge that accepts the last sample of a frame (visible next cycle).
// Backpressure: none; every valid sample is consumed, and the consumer must capture f on f_valid.
module tdm_demux_1_n #(
    parameter int N_CH = 4,
    parameter int W    = 8,
    localparam int CW  = $clog2(N_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [W-1:0]      i,
    input  logic              i_valid,
    input  logic              sof,
    output logic [CW-1:0]     s,
    output logic [N_CH*W-1:0] f,
    output logic              f_valid,
    output logic              err
);

    typedef enum logic {IDLE, COLLECT} state_t;

    state_t                   state_q, state_d;
    logic [CW-1:0]            s_q, s_d;
    logic [(N_CH-1)*W-1:0]    slot_q, slot_d;
    logic [N_CH*W-1:0]        f_q, f_d;
    logic                     fv_q, fv_d;
    logic                     err_q, err_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            s_q     <= '0;
            slot_q  <= '0;
            f_q     <= '0;
            fv_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            slot_q  <= slot_d;
            f_q     <= f_d;
            fv_q    <= fv_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        slot_d  = slot_q;
        f_d     = f_q;
        fv_d    = 1'b0;
        err_d   = 1'b0;
        if (i_valid) begin
            if (sof) begin
                // A sof inside a frame drops the partial frame and starts over.
                err_d          = (state_q == COLLECT);
                slot_d[W-1:0]  = i;
                s_d            = CW'(1);
                state_d        = COLLECT;
            end else if (state_q == IDLE) begin
                err_d = 1'b1;
            end else if (s_q == CW'(N_CH-1)) begin
                // Last channel bypasses the slot registers straight into f.
                f_d     = {i, slot_q};
                fv_d    = 1'b1;
                s_d     = '0;
                state_d = IDLE;
            end else begin
                for (int k = 1; k < N_CH-1; k++) begin
                    if (s_q == CW'(k)) begin
                        slot_d[k*W +: W] = i;
                    end
                end
                s_d = s_q + CW'(1);
            end
        end
    end

    assign s       = s_q;
    assign f       = f_q;
    assign f_valid = fv_q;
    assign err     = err_q;

endmodule

// File: tb/tb_tdm_demux_1_n.sv
// Bench for tdm_demux_1_n: directed scenarios plus randomized traffic, checked every cycle
// against a queue-based frame model.
module tb_tdm_demux_1_n;

    localparam int N_CH = 4;
    localparam int W    = 8;
    localparam int CW   = $clog2(N_CH);

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [W-1:0]      i = '0;
    logic              i_valid = 1'b0;
    logic              sof = 1'b0;
    logic [CW-1:0]     s;
    logic [N_CH*W-1:0] f;
    logic              f_valid;
    logic              err;

    tdm_demux_1_n #(.N_CH(N_CH), .W(W)) dut (
        .clk(clk), .rst(rst), .i(i), .i_valid(i_valid), .sof(sof),
        .s(s), .f(f), .f_valid(f_valid), .err(err)
    );

    always #5 clk = ~clk;

    // Model: the samples of the frame in progress, the last completed frame, and pulse flags.
    logic [W-1:0]      cur[$];
    logic [N_CH*W-1:0] m_f = '0;
    bit                m_fv = 0;
    bit                m_err = 0;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int err_seen = 0;
    int fv_seen = 0;
    int fv_cyc[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_clear();
        cur.delete();
        m_f   = '0;
        m_fv  = 0;
        m_err = 0;
    endtask

    task automatic model_step(input bit v, input bit sf, input logic [W-1:0] d);
        m_fv  = 0;
        m_err = 0;
        if (v) begin
            if (sf) begin
                m_err = (cur.size() != 0);
                cur.delete();
                cur.push_back(d);
            end else if (cur.size() == 0) begin
                m_err = 1;
            end else begin
                cur.push_back(d);
                if (cur.size() == N_CH) begin
                    for (int k = 0; k < N_CH; k++) m_f[k*W +: W] = cur[k];
                    m_fv = 1;
                    cur.delete();
                end
            end
        end
    endtask

    task automatic compare_all();
        chk("s", 64'(s), 64'(cur.size()));
        chk("f", 64'(f), 64'(m_f));
        chk("f_valid", 64'(f_valid), 64'(m_fv));
        chk("err", 64'(err), 64'(m_err));
        if (f_valid === 1'b1) begin
            fv_seen++;
            fv_cyc.push_back(cyc);
        end
        if (err === 1'b1) err_seen++;
    endtask

    task automatic cycle(input bit v, input bit sf, input logic [W-1:0] d);
        i       = d;
        i_valid = v;
        sof     = sf;
        @(posedge clk);
        cyc++;
        model_step(v, sf, d);
        #1;
        compare_all();
    endtask

    task automatic send_frame(input logic [W-1:0] base, input int gaps);
        for (int k = 0; k < N_CH; k++) begin
            cycle(1'b1, k == 0, base + W'(k));
            if (k != N_CH-1)
                for (int g = 0; g < gaps; g++) cycle(1'b0, 1'b0, W'($urandom));
        end
    endtask

    // Called at posedge+1: asserts rst mid-cycle and checks the outputs clear with no clock edge.
    task automatic async_reset();
        #2;
        rst = 1'b1;
        #1;
        model_clear();
        chk("rst_async_f", 64'(f), 64'h0);
        chk("rst_async_s", 64'(s), 64'h0);
        chk("rst_async_fv_err", {62'h0, f_valid, err}, 64'h0);
        @(posedge clk);
        cyc++;
        #1;
        compare_all();
        rst = 1'b0;
    endtask

    initial begin
        int e0, v0;
        bit v, sf;
        // Power-on reset
        repeat (3) @(posedge clk);
        #1;
        model_clear();
        compare_all();
        rst = 1'b0;

        // Orphan sample after reset
        cycle(1'b1, 1'b0, 8'h55);
        chk("orphan_err", 64'(err), 64'h1);
        chk("orphan_f", 64'(f), 64'h0);
        chk("orphan_s", 64'(s), 64'h0);

        // Normal frame
        send_frame(8'hA0, 0);
        chk("normal_f", 64'(f), 64'hA3A2A1A0);
        chk("normal_fv", 64'(f_valid), 64'h1);
        chk("model_pin_normal", 64'(m_f), 64'hA3A2A1A0);
        cycle(1'b0, 1'b0, 8'h00);
        chk("normal_fv_one_cycle", 64'(f_valid), 64'h0);

        // Gapped frame
        v0 = fv_seen;
        send_frame(8'hA0, 2);
        cycle(1'b0, 1'b0, 8'h00);
        chk("gaps_f", 64'(f), 64'hA3A2A1A0);
        chk("gaps_fv_count", 64'(fv_seen - v0), 64'h1);

        // Back-to-back frames
        send_frame(8'h10, 0);
        chk("b2b_f1", 64'(f), 64'h13121110);
        send_frame(8'h20, 0);
        chk("b2b_f2", 64'(f), 64'h23222120);
        chk("b2b_spacing", 64'(fv_cyc[fv_cyc.size()-1] - fv_cyc[fv_cyc.size()-2]), 64'h4);

        // Early sof restarts the frame
        e0 = err_seen;
        cycle(1'b1, 1'b1, 8'h30);
        cycle(1'b1, 1'b0, 8'h31);
        cycle(1'b1, 1'b1, 8'h40);
        chk("early_err", 64'(err), 64'h1);
        chk("early_f_held", 64'(f), 64'h23222120);
        cycle(1'b1, 1'b0, 8'h41);
        cycle(1'b1, 1'b0, 8'h42);
        cycle(1'b1, 1'b0, 8'h43);
        chk("early_f", 64'(f), 64'h43424140);
        chk("early_err_count", 64'(err_seen - e0), 64'h1);

        // Async reset mid-frame, then a clean frame
        cycle(1'b1, 1'b1, 8'h77);
        cycle(1'b1, 1'b0, 8'h78);
        async_reset();
        send_frame(8'hC0, 1);
        chk("post_rst_f", 64'(f), 64'hC3C2C1C0);

        // Randomized traffic
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 799) == 0) begin
                async_reset();
            end else begin
                v  = ($urandom_range(0, 9) < 7);
                sf = ($urandom_range(0, 4) == 0);
                cycle(v, sf, W'($urandom));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
